// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV32I datapath.
//   XLEN / REG_ADDR_W size the register file and the ALU.
//   ZERO_REG is the x0 index, which is hardwired to zero.
//   alu_sel_e holds the ALU operation encodings used by alu and the control decoder.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_sel_e;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the integer register file.
//   Optional macro: REGFILE_BYPASS_EN. When it is defined, the port forwards the
//   write-back data in the same cycle if the port address matches the write address.
// Ports:
//   i_regs     in   2**ADDR_W x N  flattened register contents (entry 0 is unused)
//   i_addr     in   ADDR_W         read address
//   i_wr_en    in   1              qualified write strobe (already excludes x0 and reset)
//   i_wr_addr  in   ADDR_W         write address
//   i_wr_data  in   N              write-back data
//   o_data     out  N              read data; 0 whenever i_addr is x0
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][N-1:0] i_regs,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          i_wr_en,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [N-1:0]                  i_wr_data,
  output logic [N-1:0]                  o_data
);

  logic w_is_zero;
  assign w_is_zero = (i_addr == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd = i_wr_en && (i_wr_addr == i_addr);

  always_comb begin
    o_data = i_regs[i_addr];
    if (w_fwd)     o_data = i_wr_data;
    // x0 masking has the last word, so it also wins over forwarding.
    if (w_is_zero) o_data = '0;
  end
`else
  // Without forwarding the write-side inputs have no effect on this port.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = i_regs[i_addr];
    if (w_is_zero) o_data = '0;
  end
`endif

endmodule

// File: rtl/register_file.sv
// register_file: RV32I integer register file with 2 combinational read ports and 1 write port.
//   Optional macro: REGFILE_BYPASS_EN. When it is defined, write-through forwarding is
//   performed in the read ports.
// Ports:
//   clk        in   1       core clock; writes happen on the rising edge
//   rst        in   1       asynchronous, active-high; clears every register
//   reg_write  in   1       write enable for rd
//   rs1_addr   in   ADDR_W  read port 1 address
//   rs2_addr   in   ADDR_W  read port 2 address
//   rd_addr    in   ADDR_W  write address
//   rd_data    in   N       write-back data
//   rs1_data   out  N       read port 1 data (ALU A)
//   rs2_data   out  N       read port 2 data (ALU B / immediate mux)
module register_file
  import riscv_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N-1:0]      rs1_data,
  output logic [N-1:0]      rs2_data
);

  localparam int NREG = 2**ADDR_W;

  // x0 has no storage; entries 1..NREG-1 are real flops.
  logic [N-1:0] r_regs [1:NREG-1];

  logic [NREG-1:0][N-1:0] w_regs;
  logic                   w_wr_en;

  // The reset term keeps forwarding from leaking rd_data while rst holds the outputs at 0.
  assign w_wr_en = reg_write && !rst && (rd_addr != ADDR_W'(ZERO_REG));

  // The reset branch has priority, so a write on the edge where rst is released is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (reg_write && (rd_addr != ADDR_W'(ZERO_REG))) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < NREG; i++) w_regs[i] = r_regs[i];
  end

  regfile_read_port #(.N(N), .ADDR_W(ADDR_W)) u_rd_rs1 (
    .i_regs    (w_regs),
    .i_addr    (rs1_addr),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (rd_addr),
    .i_wr_data (rd_data),
    .o_data    (rs1_data)
  );

  regfile_read_port #(.N(N), .ADDR_W(ADDR_W)) u_rd_rs2 (
    .i_regs    (w_regs),
    .i_addr    (rs2_addr),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (rd_addr),
    .i_wr_data (rd_data),
    .o_data    (rs2_data)
  );

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rs1_data, rs2_data;

  register_file #(.N(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_write (reg_write),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  event        ev_chk;
  int          checks   = 0;
  int          failures = 0;
  int          pushed   = 0;
  int          popped   = 0;
  logic [31:0] model [32];

  // Reference: architectural register array plus the read rules.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0 || rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd_addr != 5'd0 && rd_addr == a) return rd_data;
`endif
    return model[a];
  endfunction

  // Drive one cycle: set inputs at negedge, queue the expected reads, then apply the edge to the model.
  task automatic cyc(input string tag, input logic r, input logic we, input logic [4:0] rd,
                     input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    rst = r; reg_write = we; rd_addr = rd; rd_data = wd; rs1_addr = a1; rs2_addr = a2;
    if (r) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    e.tag = tag; e.e1 = ref_read(a1); e.e2 = ref_read(a2);
    sb_q.push_back(e);
    pushed++;
    -> ev_chk;
    @(posedge clk);
    if (!rst && we && rd != 5'd0) model[rd] = wd;
  endtask

  // Monitor: outputs are combinational, so they are valid whenever the driver signals a sample.
  initial begin
    exp_t e;
    forever begin
      @(ev_chk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        popped++;
        checks++;
        if (rs1_data !== e.e1) begin
          failures++;
          $display("FAIL %s rs1 addr=%0d got=%h exp=%h", e.tag, rs1_addr, rs1_data, e.e1);
        end
        checks++;
        if (rs2_data !== e.e2) begin
          failures++;
          $display("FAIL %s rs2 addr=%0d got=%h exp=%h", e.tag, rs2_addr, rs2_data, e.e2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rd, a1, a2;
    logic [31:0] wd;
    logic        we, r;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; reg_write = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0;

    // Reset holds everything at zero even with writes requested.
    cyc("rst_hold", 1, 1, 5'd4, 32'hFFFF_0000, 5'd4, 5'd0);
    cyc("rst_hold2", 1, 1, 5'd4, 32'h0000_FFFF, 5'd4, 5'd4);
    cyc("rst_rel", 0, 0, 5'd0, 32'h0, 5'd4, 5'd1);

    // Asynchronous reset mid-run, between edges.
    cyc("wr_x5", 0, 1, 5'd5, 32'h0000_1234, 5'd0, 5'd0);
    cyc("rd_x5", 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rs1_addr = 5'd5;
    #1;
    begin
      exp_t e;
      e.tag = "async_rst"; e.e1 = 32'h0; e.e2 = ref_read(rs2_addr);
      sb_q.push_back(e); pushed++; -> ev_chk;
    end
    cyc("rst_wr_ign", 1, 1, 5'd5, 32'hDEAD_0005, 5'd5, 5'd5);
    cyc("post_rst", 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Two operands for an ADD.
    cyc("wr_x1", 0, 1, 5'd1, 32'd512, 5'd0, 5'd0);
    cyc("wr_x2", 0, 1, 5'd2, 32'd512, 5'd1, 5'd0);
    cyc("rd_x1x2", 0, 0, 5'd0, 32'h0, 5'd1, 5'd2);

    // x0 writes dropped.
    cyc("wr_x0", 0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cyc("rd_x0", 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Top register, same address on both ports, neighbour untouched.
    cyc("wr_x30", 0, 1, 5'd30, 32'h3030_3030, 5'd0, 5'd0);
    cyc("wr_x31", 0, 1, 5'd31, 32'hDEAD_BEEF, 5'd30, 5'd31);
    cyc("rd_x31x31", 0, 0, 5'd0, 32'h0, 5'd31, 5'd31);
    cyc("rd_x30", 0, 0, 5'd0, 32'h0, 5'd30, 5'd31);

    // Same-cycle read/write of x7 (old value or forwarded, depending on build).
    cyc("wr_x7_old", 0, 1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
    cyc("rdwr_x7", 0, 1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
    cyc("rd_x7", 0, 0, 5'd0, 32'h0, 5'd7, 5'd0);

    // reg_write low: x3 keeps its reset value.
    for (int k = 0; k < 3; k++) cyc("no_we_x3", 0, 0, 5'd3, 32'h55, 5'd3, 5'd3);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 4) == 0) ? a1 : 5'($urandom_range(0, 31));
      cyc("random", r, we, rd, wd, a1, a2);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0 || popped != pushed) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d popped=%0d pushed=%0d", sb_q.size(), popped, pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
